// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard byte decoder: pops receiver FIFO bytes and turns E0/F0-prefixed scan codes into key events.
// Latency: ready sampled at edge k -> nextdata_n low for one cycle -> key_valid pulse after edge k+3.
// Backpressure: en=0 holds off new pops only; a byte already popped is always decoded. Peak rate 1 byte/4 cycles.
module ps2_kbd_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  input  logic             clr_err,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_held,
  output logic [CNT_W-1:0] key_cnt,
  output logic             err_ovf,
  output logic             err_proto
);

  typedef enum logic [1:0] {IDLE, POP, GAP, DECODE} state_t;

  localparam logic [7:0]       BYTE_EXT = 8'hE0;
  localparam logic [7:0]       BYTE_BRK = 8'hF0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic       do_pop;
  logic       do_decode;
  logic [7:0] byte_q;
  logic       ext_pend;
  logic       brk_pend;
  logic [7:0] held_code;
  logic       held_ext;
  logic       is_ext;
  logic       is_brk;
  logic       same_key;

  // The event's key matches the key we believe is currently down.
  assign is_ext   = (byte_q == BYTE_EXT);
  assign is_brk   = (byte_q == BYTE_BRK);
  assign same_key = key_held && (byte_q == held_code) && (ext_pend == held_ext);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: pop when enabled and data waits, then walk POP/GAP/DECODE unconditionally.
  always_comb begin
    state_nxt = state;
    do_pop    = 1'b0;
    do_decode = 1'b0;
    case (state)
      IDLE: begin
        if (en && ready) begin
          do_pop    = 1'b1;
          state_nxt = POP;
        end
      end
      POP:    state_nxt = GAP;
      GAP:    state_nxt = DECODE;
      DECODE: begin
        do_decode = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pop strobe and byte capture; strobe is low only for the cycle after the IDLE pop decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      nextdata_n <= 1'b1;
      byte_q     <= 8'h00;
    end else begin
      nextdata_n <= ~do_pop;
      if (do_pop) byte_q <= data;
    end
  end

  // Prefix tracking, event generation, held-key tracking and press counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_held  <= 1'b0;
      key_cnt   <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      held_code <= 8'h00;
      held_ext  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (do_decode) begin
        if (is_ext) begin
          // E0 after F0 is out of order: drop both prefixes (error flagged below).
          if (brk_pend) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end else begin
            ext_pend <= 1'b1;
          end
        end else if (is_brk) begin
          brk_pend <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_code  <= byte_q;
          key_ext   <= ext_pend;
          key_break <= brk_pend;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
          if (!brk_pend) begin
            // Typematic repeats of the held key are not new presses.
            if (!same_key) begin
              key_cnt   <= key_cnt + CNT_ONE;
              held_code <= byte_q;
              held_ext  <= ext_pend;
              key_held  <= 1'b1;
            end
          end else if (same_key) begin
            key_held <= 1'b0;
          end
        end
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      if (overflow)     err_ovf <= 1'b1;
      else if (clr_err) err_ovf <= 1'b0;
      if (do_decode && brk_pend && (is_ext || is_brk)) err_proto <= 1'b1;
      else if (clr_err)                                err_proto <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: behavioural receiver FIFO, scan-code model and event scoreboard.
// Expected events are queued when bytes are offered and compared as key_valid pulses appear.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_ps2_kbd_ctrl;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       held;
    logic [7:0] cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, en, ready, overflow, clr_err;
  logic [7:0] data;
  logic       nextdata_n, key_valid, key_ext, key_break, key_held, err_ovf, err_proto;
  logic [7:0] key_code;
  logic [7:0] key_cnt;

  int         n_vec = 0;
  int         n_bad = 0;
  int         pop_cnt = 0;
  int         ev_cnt = 0;
  logic       prev_low = 1'b0;

  logic [7:0] rxq[$];
  ev_t        expq[$];

  // Reference decoder state
  logic       m_ext, m_brk, m_held, m_hext, m_perr;
  logic [7:0] m_hcode, m_cnt;

  ps2_kbd_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .ready(ready), .data(data),
    .overflow(overflow), .clr_err(clr_err), .nextdata_n(nextdata_n),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_held(key_held), .key_cnt(key_cnt),
    .err_ovf(err_ovf), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_perr = 0;
    m_hcode = 8'h00; m_cnt = 8'h00;
  endtask

  // Offer one byte to the receiver and predict what the decoder does with it.
  task automatic send(input logic [7:0] b);
    ev_t e;
    if (b == 8'hE0) begin
      if (m_brk) begin m_perr = 1; m_ext = 0; m_brk = 0; end
      else m_ext = 1;
    end else if (b == 8'hF0) begin
      if (m_brk) m_perr = 1;
      m_brk = 1;
    end else begin
      if (!m_brk) begin
        if (!m_held || b != m_hcode || m_ext != m_hext) begin
          m_cnt = m_cnt + 8'd1; m_hcode = b; m_hext = m_ext; m_held = 1;
        end
      end else if (m_held && b == m_hcode && m_ext == m_hext) begin
        m_held = 0;
      end
      e.code = b; e.ext = m_ext; e.brk = m_brk; e.held = m_held; e.cnt = m_cnt;
      expq.push_back(e);
      m_ext = 0; m_brk = 0;
    end
    rxq.push_back(b);
  endtask

  task automatic drain(input bit wiggle_en);
    int t = 0;
    while ((rxq.size() != 0 || expq.size() != 0) && t < 3000) begin
      @(posedge clk); #1;
      if (wiggle_en) en = 1'($urandom_range(0, 1));
      t++;
    end
    en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_timeout", 32'(t >= 3000), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Receiver FIFO behaviour plus output monitor, all on the falling edge.
  initial begin
    ready = 1'b0;
    data  = 8'h00;
    forever begin
      ev_t e;
      @(negedge clk);
      if (nextdata_n == 1'b0) begin
        pop_cnt++;
        chk("nd_single_cycle", 32'(prev_low), 0);
        if (rxq.size() != 0) void'(rxq.pop_front());
      end
      prev_low = ~nextdata_n;
      if (key_valid) begin
        ev_cnt++;
        if (expq.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          e = expq.pop_front();
          chk("ev_code", 32'(key_code),  32'(e.code));
          chk("ev_ext",  32'(key_ext),   32'(e.ext));
          chk("ev_brk",  32'(key_break), 32'(e.brk));
          chk("ev_held", 32'(key_held),  32'(e.held));
          chk("ev_cnt",  32'(key_cnt),   32'(e.cnt));
        end
      end
      ready = (rxq.size() != 0);
      data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end
  end

  initial begin
    int p0, e0, to;
    logic [7:0] rb;
    rst = 1'b1; en = 1'b1; overflow = 1'b0; clr_err = 1'b0;
    model_reset();
    do_reset();
    @(negedge clk);
    chk("rst_nextdata_n", 32'(nextdata_n), 1);
    chk("rst_key_valid",  32'(key_valid), 0);
    chk("rst_key_code",   32'(key_code), 0);
    chk("rst_key_held",   32'(key_held), 0);
    chk("rst_key_cnt",    32'(key_cnt), 0);
    chk("rst_errs",       32'({err_ovf, err_proto, key_ext, key_break}), 0);

    // Make then break of one key
    @(posedge clk); #1;
    p0 = pop_cnt; e0 = ev_cnt;
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain(0);
    chk("t1_pops",   32'(pop_cnt - p0), 3);
    chk("t1_events", 32'(ev_cnt - e0), 2);
    chk("t1_cnt",    32'(key_cnt), 1);
    chk("t1_held",   32'(key_held), 0);

    // Extended key make/break
    do_reset();
    e0 = ev_cnt;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain(0);
    chk("t2_events", 32'(ev_cnt - e0), 2);
    chk("t2_cnt",    32'(key_cnt), 1);

    // Typematic repeats are not counted
    do_reset();
    e0 = ev_cnt;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain(0);
    chk("t3_events", 32'(ev_cnt - e0), 4);
    chk("t3_cnt",    32'(key_cnt), 1);
    send(8'h32);
    drain(0);
    chk("t3_cnt2",   32'(key_cnt), 2);

    // Press counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h10 : 8'h11);
    drain(0);
    chk("t4_cnt255", 32'(key_cnt), 255);
    send(8'h11);
    drain(0);
    chk("t4_wrap",   32'(key_cnt), 0);

    // Protocol error, overflow, clear
    do_reset();
    e0 = ev_cnt;
    send(8'hF0); send(8'hE0); send(8'h1C);
    drain(0);
    chk("t5_proto",  32'(err_proto), 1);
    chk("t5_events", 32'(ev_cnt - e0), 1);
    chk("t5_ovf0",   32'(err_ovf), 0);
    overflow = 1'b1; @(posedge clk); #1 overflow = 1'b0;
    chk("t5_ovf",    32'(err_ovf), 1);
    overflow = 1'b1; clr_err = 1'b1; @(posedge clk); #1;
    overflow = 1'b0;
    chk("t5_ovf_prio", 32'(err_ovf), 1);
    @(posedge clk); #1 clr_err = 1'b0;
    chk("t5_clr", 32'({err_ovf, err_proto}), 0);

    // Reset while the popped byte sits in GAP: it is discarded silently
    do_reset();
    send(8'h1C);
    void'(expq.pop_back());
    model_reset();
    to = 0;
    while (nextdata_n !== 1'b0 && to < 50) begin @(negedge clk); to++; end
    chk("t6_pop_seen", 32'(to >= 50), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_nd",    32'(nextdata_n), 1);
    chk("t6_valid", 32'(key_valid), 0);
    chk("t6_outs",  32'({key_code, key_ext, key_break, key_held, key_cnt, err_ovf, err_proto}), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("t6_no_evt", 32'(key_cnt), 0);

    // en low holds off popping while data waits
    p0 = pop_cnt;
    en = 1'b0;
    send(8'h1C);
    repeat (12) @(posedge clk);
    #1;
    chk("t7_no_pop", 32'(pop_cnt - p0), 0);
    chk("t7_nd",     32'(nextdata_n), 1);
    chk("t7_queued", 32'(rxq.size()), 1);
    en = 1'b1;
    drain(0);
    chk("t7_cnt", 32'(key_cnt), 1);

    // Random byte stream with en toggling at random
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = 8'h1C;
        3: rb = 8'h75;
        default: begin
          rb = 8'($urandom_range(0, 255));
          if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h32;
        end
      endcase
      send(rb);
    end
    drain(1);
    chk("t8_proto", 32'(err_proto), 32'(m_perr));
    chk("t8_cnt",   32'(key_cnt), 32'(m_cnt));
    chk("t8_held",  32'(key_held), 32'(m_held));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
